// File: rtl/seg_display_arbiter.sv
// Fixed-priority arbiter that shares the 8-digit seven-segment display between four view sources.
// The current owner keeps the display for a minimum hold time; the last shown value stays up when nobody requests.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 49999,
  parameter int unsigned CNT_W       = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [3:0]   i_req,
  input  logic [127:0] i_data,
  output logic [31:0]  o_data,
  output logic [3:0]   o_grant,
  output logic         o_busy,
  output logic         o_switch
);

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, OWN, OPEN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       grant_n;
  logic [31:0]      data_n;
  logic             switch_n;

  logic [3:0] win, hi_req, hi_win, take_grant;
  logic       owner_req;

  function automatic logic [31:0] sel_data(input logic [3:0] g, input logic [127:0] d);
    logic [31:0] r;
    r = '0;
    for (int unsigned k = 0; k < 4; k++)
      if (g[k]) r = d[32*k +: 32];
    return r;
  endfunction

  always_comb begin
    win        = i_req & (~i_req + 4'd1);
    // Requests strictly above the owner in priority: bits below its one-hot position.
    hi_req     = i_req & (o_grant - 4'd1);
    hi_win     = hi_req & (~hi_req + 4'd1);
    owner_req  = |(i_req & o_grant);
    take_grant = (|hi_req) ? hi_win : win;

    state_n  = state;
    cnt_n    = cnt;
    grant_n  = o_grant;
    data_n   = o_data;
    switch_n = 1'b0;

    case (state)
      IDLE: begin
        if (|i_req) begin
          grant_n  = win;
          data_n   = sel_data(win, i_data);
          cnt_n    = HOLD;
          switch_n = 1'b1;
          state_n  = (HOLD == '0) ? OPEN : OWN;
        end
      end
      OWN: begin
        if (owner_req) data_n = sel_data(o_grant, i_data);
        cnt_n = (cnt == '0) ? '0 : cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) state_n = OPEN;
      end
      OPEN: begin
        // Preemption by a higher-priority source, or handover when the owner has let go.
        if ((|hi_req) || (!owner_req && (|i_req))) begin
          grant_n  = take_grant;
          data_n   = sel_data(take_grant, i_data);
          cnt_n    = HOLD;
          switch_n = 1'b1;
          state_n  = (HOLD == '0) ? OPEN : OWN;
        end else if (owner_req) begin
          data_n = sel_data(o_grant, i_data);
        end else begin
          grant_n = '0;
          state_n = IDLE;
        end
      end
      default: begin
        grant_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      o_grant  <= '0;
      o_data   <= '0;
      o_switch <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      o_grant  <= grant_n;
      o_data   <= data_n;
      o_switch <= switch_n;
    end
  end

  assign o_busy = |o_grant;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: per-cycle comparison against an owner/hold-time model,
// plus directed scenarios with hand-computed expectations.
module tb_seg_display_arbiter;
  localparam int unsigned HOLD = 4;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [3:0]   i_req = '0;
  logic [31:0]  d [4];
  logic [127:0] i_data;
  logic [31:0]  o_data;
  logic [3:0]   o_grant;
  logic         o_busy;
  logic         o_switch;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  assign i_data = {d[3], d[2], d[1], d[0]};

  always #5 i_clk = ~i_clk;

  seg_display_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(16)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_grant (o_grant),
    .o_busy  (o_busy),
    .o_switch(o_switch)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 = none), cycles of hold still to serve, shown value.
  int          m_owner = -1;
  int          m_hold  = 0;
  logic [31:0] m_data  = '0;
  logic        m_sw    = 1'b0;

  function automatic int lowest(input logic [3:0] v, input int below);
    for (int k = 0; k < below; k++)
      if (v[k]) return k;
    return -1;
  endfunction

  always @(posedge i_clk) begin : model
    int w, hi, nxt;
    if (i_rst) begin
      m_owner = -1; m_hold = 0; m_data = '0; m_sw = 1'b0;
    end else begin
      m_sw = 1'b0;
      nxt  = -1;
      w    = lowest(i_req, 4);
      if (m_owner < 0) begin
        nxt = w;
      end else if (m_hold > 0) begin
        if (i_req[m_owner]) m_data = d[m_owner];
        m_hold = m_hold - 1;
      end else begin
        hi = lowest(i_req, m_owner);
        if (hi >= 0) nxt = hi;
        else if (i_req[m_owner]) m_data = d[m_owner];
        else if (w >= 0) nxt = w;
        else m_owner = -1;
      end
      if (nxt >= 0) begin
        m_owner = nxt; m_data = d[nxt]; m_hold = HOLD; m_sw = 1'b1;
      end
    end
  end

  always @(posedge i_clk) begin : compare
    logic [3:0] eg;
    #1;
    if (started) begin
      eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      check("model_grant",  32'(o_grant),  32'(eg));
      check("model_data",   o_data,        m_data);
      check("model_switch", 32'(o_switch), 32'(m_sw));
      check("model_busy",   32'(o_busy),   32'(m_owner >= 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  initial begin
    d[0] = 32'h11111111; d[1] = 32'h22222222; d[2] = 32'h33333333; d[3] = 32'h44444444;
    i_rst = 1'b1;
    i_req = 4'b1111;
    started = 1'b1;
    cyc(2);
    check("rst_grant",  32'(o_grant),  32'h0);
    check("rst_data",   o_data,        32'h0);
    check("rst_switch", 32'(o_switch), 32'h0);
    i_rst = 1'b0;
    cyc(1);
    check("first_grant",  32'(o_grant),  32'h1);
    check("first_switch", 32'(o_switch), 32'h1);
    check("first_data",   o_data,        32'h11111111);

    // Single low-priority request, then release after the hold.
    i_rst = 1'b1; cyc(1); i_rst = 1'b0;
    i_req = 4'b0100; d[2] = 32'h00AB0012;
    cyc(1);
    check("s2_grant",  32'(o_grant),  32'h4);
    check("s2_data",   o_data,        32'h00AB0012);
    check("s2_switch", 32'(o_switch), 32'h1);
    i_req = 4'b0000;
    cyc(4);
    check("s2_hold_grant", 32'(o_grant), 32'h4);
    cyc(1);
    check("s2_release_grant",  32'(o_grant),  32'h0);
    check("s2_release_data",   o_data,        32'h00AB0012);
    check("s2_release_switch", 32'(o_switch), 32'h0);

    // Higher priority arrives mid-hold: waits until the hold expires.
    i_req = 4'b1000;
    cyc(1);
    check("s3_grant", 32'(o_grant), 32'h8);
    i_req = 4'b1001;
    cyc(4);
    check("s3_held", 32'(o_grant), 32'h8);
    cyc(1);
    check("s3_preempt", 32'(o_grant),  32'h1);
    check("s3_switch",  32'(o_switch), 32'h1);
    cyc(1);
    check("s3_one_pulse", 32'(o_switch), 32'h0);

    // Lower priority waits while the open owner keeps requesting.
    i_rst = 1'b1; cyc(1); i_rst = 1'b0;
    i_req = 4'b0010;
    cyc(5);
    i_req = 4'b0110;
    cyc(2);
    check("s4_keep_grant",  32'(o_grant),  32'h2);
    check("s4_keep_switch", 32'(o_switch), 32'h0);
    i_req = 4'b0100;
    cyc(1);
    check("s4_grant",  32'(o_grant),  32'h4);
    check("s4_switch", 32'(o_switch), 32'h1);
    check("s4_data",   o_data,        32'h00AB0012);

    // Data tracking with one-cycle lag, frozen once the owner drops its request.
    i_rst = 1'b1; cyc(1); i_rst = 1'b0;
    i_req = 4'b0001; d[0] = 32'hA0;
    cyc(1);
    check("s5_data0", o_data, 32'hA0);
    d[0] = 32'hA1; cyc(1);
    check("s5_data1", o_data, 32'hA1);
    d[0] = 32'hA2; cyc(1);
    check("s5_data2", o_data, 32'hA2);
    d[0] = 32'hDEADBEEF; i_req = 4'b0000;
    cyc(1);
    check("s5_frozen_data",  o_data,       32'hA2);
    check("s5_frozen_grant", 32'(o_grant), 32'h1);

    // Reset during the hold, then a full fresh hold.
    i_rst = 1'b1;
    cyc(1);
    check("s6_rst_grant", 32'(o_grant), 32'h0);
    check("s6_rst_data",  o_data,       32'h0);
    i_rst = 1'b0; i_req = 4'b0010;
    cyc(1);
    check("s6_grant", 32'(o_grant), 32'h2);
    i_req = 4'b0001;
    cyc(4);
    check("s6_hold_grant", 32'(o_grant), 32'h2);
    cyc(1);
    check("s6_preempt_grant",  32'(o_grant),  32'h1);
    check("s6_preempt_switch", 32'(o_switch), 32'h1);

    // Mixed request patterns, checked by the model alone.
    repeat (60) begin
      i_req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) i_req = 4'b0000;
      for (int k = 0; k < 4; k++) d[k] = $urandom;
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
